// File: rtl/register_file_read_sequencer_pkg.sv
// Shared constants for the register-file read/write side.
// Select encodings, fixed addresses and sequencer state encodings.
package register_file_read_sequencer_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        SEL_IR   = 2'b00,
        SEL_D    = 2'b01,
        SEL_ZERO = 2'b10,
        SEL_ILL  = 2'b11
    } src_sel_e;

    localparam logic [ADDR_W-1:0] ADDR_FIXED_D = 4'hD;
    localparam logic [ADDR_W-1:0] ADDR_ZERO    = 4'h0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_A  = 3'd1,
        ST_RD_B  = 3'd2,
        ST_CAP_B = 3'd3,
        ST_VALID = 3'd4
    } rfs_state_e;

endpackage

// File: rtl/register_file_read_sequencer_if.sv
// Request, register-file port and operand handshake bundle.
// master = requester/consumer/register file, slave = sequencer.
interface register_file_read_sequencer_if;
    import register_file_read_sequencer_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        src_a_sel;
    logic [1:0]        src_b_sel;
    logic [ADDR_W-1:0] ir_a;
    logic [ADDR_W-1:0] ir_b;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              sel_err;

    modport master (
        output req_valid, src_a_sel, src_b_sel, ir_a, ir_b,
        output rf_data, op_ready,
        input  req_ready, rf_addr, op_valid, op_a, op_b, sel_err
    );

    modport slave (
        input  req_valid, src_a_sel, src_b_sel, ir_a, ir_b,
        input  rf_data, op_ready,
        output req_ready, rf_addr, op_valid, op_a, op_b, sel_err
    );

endinterface

// File: rtl/register_file_read_sequencer_decode.sv
// Per-operand read-address decode.
// Illegal select reads address 0 and flags an error.
module rf_read_address_decode
    import register_file_read_sequencer_pkg::*;
(
    input  logic [1:0]        sel,
    input  logic [ADDR_W-1:0] ir,
    output logic [ADDR_W-1:0] addr,
    output logic              err
);

    // Map the select code onto a register-file address.
    always_comb begin
        addr = ADDR_ZERO;
        err  = 1'b0;
        unique case (src_sel_e'(sel))
            SEL_IR:   addr = ir;
            SEL_D:    addr = ADDR_FIXED_D;
            SEL_ZERO: addr = ADDR_ZERO;
            SEL_ILL: begin
                addr = ADDR_ZERO;
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/register_file_read_sequencer.sv
// Operand-fetch sequencer over a single registered-read port.
// Reads A then B; a shared address skips the second capture.
module register_file_read_sequencer
    import register_file_read_sequencer_pkg::*;
(
    input logic clk,
    input logic reset,
    register_file_read_sequencer_if.slave bus
);

    rfs_state_e        state;
    rfs_state_e        state_nxt;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [ADDR_W-1:0] dec_addr_a;
    logic [ADDR_W-1:0] dec_addr_b;
    logic              dec_err_a;
    logic              dec_err_b;
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] op_b_q;
    logic              err_q;
    logic              same_addr;

    rf_read_address_decode u_dec_a (
        .sel  (bus.src_a_sel),
        .ir   (bus.ir_a),
        .addr (dec_addr_a),
        .err  (dec_err_a)
    );

    rf_read_address_decode u_dec_b (
        .sel  (bus.src_b_sel),
        .ir   (bus.ir_b),
        .addr (dec_addr_b),
        .err  (dec_err_b)
    );

    assign same_addr = (addr_a == addr_b);
    assign bus.op_a    = op_a_q;
    assign bus.op_b    = op_b_q;
    assign bus.sel_err = err_q;

    // State register; reset abandons any request in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-state port drive.
    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        bus.rf_addr   = ADDR_ZERO;
        bus.op_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_nxt = ST_RD_A;
                end
            end
            ST_RD_A: begin
                bus.rf_addr = addr_a;
                state_nxt   = ST_RD_B;
            end
            ST_RD_B: begin
                bus.rf_addr = addr_b;
                state_nxt   = same_addr ? ST_VALID : ST_CAP_B;
            end
            ST_CAP_B: begin
                bus.rf_addr = addr_b;
                state_nxt   = ST_VALID;
            end
            ST_VALID: begin
                bus.op_valid = 1'b1;
                if (bus.op_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Latch the request at acceptance and capture read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_a <= ADDR_ZERO;
            addr_b <= ADDR_ZERO;
            err_q  <= 1'b0;
            op_a_q <= '0;
            op_b_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        addr_a <= dec_addr_a;
                        addr_b <= dec_addr_b;
                        err_q  <= dec_err_a | dec_err_b;
                    end
                end
                ST_RD_B: begin
                    op_a_q <= bus.rf_data;
                    if (same_addr) begin
                        op_b_q <= bus.rf_data;
                    end
                end
                ST_CAP_B: begin
                    op_b_q <= bus.rf_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_register_file_read_sequencer.sv
// Bench for register_file_read_sequencer.
// Registered-read file model r[i] = 16'h1000 + i.
module tb_register_file_read_sequencer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    register_file_read_sequencer_if bus ();

    register_file_read_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Register file with one-cycle read latency.
    logic [15:0] rf_q = 16'h0;
    always @(posedge clk) rf_q <= 16'h1000 + {12'h0, bus.rf_addr};
    assign bus.rf_data = rf_q;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] ref_addr(input logic [1:0] sel,
                                            input logic [3:0] ir);
        if (sel == 2'd0) return ir;
        if (sel == 2'd1) return 4'hD;
        return 4'h0;
    endfunction

    task automatic chk_reset_vals();
        chk("rst_op_valid", 16'(bus.op_valid), 16'h0);
        chk("rst_rf_addr", 16'(bus.rf_addr), 16'h0);
        chk("rst_op_a", bus.op_a, 16'h0);
        chk("rst_op_b", bus.op_b, 16'h0);
        chk("rst_sel_err", 16'(bus.sel_err), 16'h0);
    endtask

    // One request from IDLE through the handshake back to IDLE.
    task automatic run_req(input logic [1:0] sa, input logic [1:0] sb,
                           input logic [3:0] ia, input logic [3:0] ib,
                           input int hold, input bit keep_valid,
                           input bit scramble);
        logic [3:0]  ea;
        logic [3:0]  eb;
        logic        ee;
        int          lat;
        logic [15:0] xa;
        logic [15:0] xb;
        logic [3:0]  seq[$];
        ea  = ref_addr(sa, ia);
        eb  = ref_addr(sb, ib);
        ee  = (sa == 2'd3) || (sb == 2'd3);
        lat = (ea == eb) ? 3 : 4;
        xa  = 16'h1000 + {12'h0, ea};
        xb  = 16'h1000 + {12'h0, eb};
        seq = {ea, eb};
        if (lat == 4) seq.push_back(eb);

        chk("idle_req_ready", 16'(bus.req_ready), 16'h1);
        chk("idle_rf_addr", 16'(bus.rf_addr), 16'h0);
        bus.src_a_sel = sa;
        bus.src_b_sel = sb;
        bus.ir_a      = ia;
        bus.ir_b      = ib;
        bus.req_valid = 1'b1;
        step();
        if (scramble) begin
            bus.ir_a      = ~ia;
            bus.ir_b      = ~ib;
            bus.src_a_sel = 2'($urandom);
            bus.src_b_sel = 2'($urandom);
        end
        if (!keep_valid) bus.req_valid = 1'b0;

        for (int k = 1; k < lat; k++) begin
            chk("busy_op_valid", 16'(bus.op_valid), 16'h0);
            chk("busy_req_ready", 16'(bus.req_ready), 16'h0);
            chk("rf_addr_seq", 16'(bus.rf_addr), 16'(seq[k-1]));
            bus.op_ready = 1'($urandom);
            step();
        end
        bus.op_ready = 1'b0;

        for (int h = 0; h <= hold; h++) begin
            if (h > 0) step();
            chk("valid_op_valid", 16'(bus.op_valid), 16'h1);
            chk("valid_req_ready", 16'(bus.req_ready), 16'h0);
            chk("valid_op_a", bus.op_a, xa);
            chk("valid_op_b", bus.op_b, xb);
            chk("valid_sel_err", 16'(bus.sel_err), 16'(ee));
        end

        bus.op_ready = 1'b1;
        step();
        bus.op_ready = 1'b0;
        chk("done_op_valid", 16'(bus.op_valid), 16'h0);
        chk("done_req_ready", 16'(bus.req_ready), 16'h1);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.op_ready  = 1'b0;
        bus.src_a_sel = 2'd0;
        bus.src_b_sel = 2'd0;
        bus.ir_a      = 4'h0;
        bus.ir_b      = 4'h0;
        reset         = 1'b1;
        step();
        step();
        chk_reset_vals();
        chk("rst_req_ready", 16'(bus.req_ready), 16'h1);
        reset = 1'b0;
        step();

        // A from ir, B fixed D: unequal, 4-cycle latency.
        run_req(2'd0, 2'd1, 4'h3, 4'h0, 0, 1'b0, 1'b0);
        // A fixed 0, B from ir=0: equal, CAP_B skipped.
        run_req(2'd2, 2'd0, 4'h5, 4'h0, 0, 1'b0, 1'b0);
        // Illegal B select.
        run_req(2'd0, 2'd3, 4'h7, 4'h9, 0, 1'b0, 1'b0);
        // Consumer stalls five cycles in VALID.
        run_req(2'd1, 2'd1, 4'h0, 4'h0, 5, 1'b0, 1'b0);
        // Inputs change after acceptance with req_valid held.
        run_req(2'd0, 2'd0, 4'h4, 4'h6, 1, 1'b1, 1'b1);
        run_req(2'd0, 2'd0, 4'h6, 4'h6, 0, 1'b0, 1'b0);

        // Reset while in RD_B abandons the request.
        bus.src_a_sel = 2'd0;
        bus.src_b_sel = 2'd0;
        bus.ir_a      = 4'h2;
        bus.ir_b      = 4'hA;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        step();
        chk("rdb_rf_addr", 16'(bus.rf_addr), 16'hA);
        reset = 1'b1;
        step();
        chk_reset_vals();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("abandon_op_valid", 16'(bus.op_valid), 16'h0);
            step();
        end

        // Random requests against the reference model.
        for (int t = 0; t < 40; t++) begin
            run_req(2'($urandom), 2'($urandom), 4'($urandom), 4'($urandom),
                    int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file_read_sequencer.md
REGISTER_FILE_READ_SEQUENCER -- requirements
Module: register_file_read_sequencer

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset; all state updates on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  operand-fetch request present.
REQ-005 req_ready  output  1  sequencer can accept a request.
REQ-006 src_a_sel  input  2  operand A read-address select: 00 = ir_a, 01 = 4'hD, 10 = 4'h0, 11 = illegal.
REQ-007 src_b_sel  input  2  operand B read-address select, same encoding as src_a_sel.
REQ-008 ir_a, ir_b  input  4 each  instruction-register address fields for A and B.
REQ-009 rf_addr  output  4  register-file read address (single read port).
REQ-010 rf_data  input  16  register-file read data, valid one cycle after rf_addr is driven (registered read).
REQ-011 op_valid  output  1  operands op_a and op_b are valid.
REQ-012 op_ready  input  1  consumer accepts the operands.
REQ-013 op_a, op_b  output  16 each  fetched operands.
REQ-014 sel_err  output  1  an illegal select (11) occurred in the current request; valid while op_valid.

Function
REQ-015 SHALL implement FSM states IDLE, RD_A, RD_B, CAP_B and VALID.
REQ-016 IDLE: req_ready=1 and rf_addr=4'h0; on req_valid, SHALL latch both decoded addresses and sel_err, then go to RD_A.
REQ-017 Address decode SHALL apply per operand: 00 -> ir field; 01 -> 4'hD; 10 -> 4'h0; 11 -> 4'h0 with sel_err set.
REQ-018 RD_A: rf_addr = addr_a; next state RD_B.
REQ-019 RD_B: rf_addr = addr_b; SHALL capture rf_data into op_a at the end of the cycle.
REQ-020 RD_B exit: if addr_b == addr_a, SHALL also copy rf_data into op_b and go directly to VALID; otherwise go to CAP_B.
REQ-021 CAP_B: rf_addr = addr_b; SHALL capture rf_data into op_b; next state VALID.
REQ-022 VALID: op_valid=1; op_a, op_b and sel_err SHALL be held stable until op_ready=1, then go to IDLE.
REQ-023 req_ready SHALL be 0 in every state except IDLE; a request is never accepted in the same cycle as a VALID handshake.
REQ-024 Latency from acceptance edge to op_valid: 3 cycles when addresses are equal, 4 cycles otherwise.
REQ-025 Request inputs SHALL be sampled only at acceptance; later changes SHALL NOT affect the request in flight.
REQ-026 op_ready SHALL be ignored outside VALID.

Reset
REQ-027 On reset: state=IDLE, rf_addr=4'h0, op_valid=0, op_a=op_b=16'h0000, sel_err=0, latched addresses=0.
REQ-028 Reset SHALL take priority over all other events, including acceptance and the VALID handshake, and SHALL abandon any request in flight without asserting op_valid.

Structure
REQ-029 Select encodings (00/01/10/11), fixed addresses 4'hD and 4'h0, and FSM state encodings SHALL reside in a shared project constants include, also used by the write-side logic.
REQ-030 The per-operand decode SHALL be a combinational sub-module, rf_read_address_decode, instantiated twice (A, B).

Verification
REQ-031 Bench SHALL model a 16x16 registered-read register file with r[i] = 16'h1000+i and cover the following scenarios.
REQ-032 src_a_sel=00, ir_a=3, src_b_sel=01 -> rf_addr sequence 3, D, D; op_a=16'h1003, op_b=16'h100D; op_valid 4 cycles after acceptance; sel_err=0.
REQ-033 src_a_sel=10, src_b_sel=00, ir_b=0 -> addresses equal; op_a=op_b=16'h1000; op_valid after 3 cycles; CAP_B skipped.
REQ-034 src_b_sel=11 -> op_b=16'h1000 and sel_err=1 while op_valid.
REQ-035 op_ready held at 0 for 5 cycles in VALID -> outputs stable and req_ready=0; op_ready=1 -> IDLE next cycle, req_ready=1.
REQ-036 reset asserted in RD_B -> next cycle all outputs at reset values; op_valid never asserted for the abandoned request.
REQ-037 req_valid held with ir_a changed after acceptance -> operands reflect the value sampled at acceptance; next request accepted only after the handshake.
